// File: rtl/cpu_pipe_ctrl_if.sv
// Pipeline-side signal bundle for cpu_pipe_ctrl.
// The pipeline drives through the master modport. The controller uses the slave modport.
interface cpu_pipe_ctrl_if;
    logic        mem_busy;
    logic        ld_hazard;
    logic        mem_en;
    logic [29:0] mem_pc;
    logic [2:0]  mem_exp_code;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  irq;
    logic [4:0]  creg_rd_addr;
    logic [31:0] creg_rd_data;
    logic        exe_mode;
    logic        if_stall;
    logic        id_stall;
    logic        ex_stall;
    logic        mem_stall;
    logic        if_flush;
    logic        id_flush;
    logic        ex_flush;
    logic        mem_flush;
    logic [29:0] new_pc;

    modport master (
        output mem_busy, ld_hazard, mem_en, mem_pc, mem_exp_code, mem_ctrl_op,
               mem_dst_addr, mem_wdata, irq, creg_rd_addr,
        input  creg_rd_data, exe_mode, if_stall, id_stall, ex_stall, mem_stall,
               if_flush, id_flush, ex_flush, mem_flush, new_pc
    );

    modport slave (
        input  mem_busy, ld_hazard, mem_en, mem_pc, mem_exp_code, mem_ctrl_op,
               mem_dst_addr, mem_wdata, irq, creg_rd_addr,
        output creg_rd_data, exe_mode, if_stall, id_stall, ex_stall, mem_stall,
               if_flush, id_flush, ex_flush, mem_flush, new_pc
    );
endinterface

// File: rtl/cpu_pipe_ctrl.sv
// Five-stage pipeline controller. Produces per-stage stall/flush and owns the control registers.
// Exceptions, ERET, HALT/wake and interrupts all resolve at the MEM stage.
module cpu_pipe_ctrl (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    cpu_pipe_ctrl_if.slave  bus
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [1:0] OP_WRCR = 2'd1;
    localparam logic [1:0] OP_ERET = 2'd2;
    localparam logic [1:0] OP_HALT = 2'd3;

    localparam logic [4:0] CR_STATUS = 5'd0;
    localparam logic [4:0] CR_CAUSE  = 5'd1;
    localparam logic [4:0] CR_VECTOR = 5'd2;
    localparam logic [4:0] CR_EPC    = 5'd3;
    localparam logic [4:0] CR_MASK   = 5'd4;

    logic [0:0]  state;
    logic        ie;
    logic        mode;
    logic        saved_ie;
    logic        saved_mode;
    logic [2:0]  cause;
    logic [29:0] vector;
    logic [29:0] epc;
    logic [7:0]  mask;

    logic        int_pend;
    logic        take_exc;
    logic        do_wake;
    logic        do_eret;
    logic        do_halt;
    logic        do_wrcr;
    logic [2:0]  trap_code;
    logic [29:0] pc_plus1;

    assign int_pend = ie & (|(bus.irq & ~mask));
    assign pc_plus1 = bus.mem_pc + 30'd1;
    assign bus.exe_mode = mode;

    // Event decode in priority order. Stall and flush are never both raised for one stage.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the priority chain infers a latch.
        bus.if_stall  = 1'b0;
        bus.id_stall  = 1'b0;
        bus.ex_stall  = 1'b0;
        bus.mem_stall = 1'b0;
        bus.if_flush  = 1'b0;
        bus.id_flush  = 1'b0;
        bus.ex_flush  = 1'b0;
        bus.mem_flush = 1'b0;
        bus.new_pc    = 30'd0;
        take_exc      = 1'b0;
        do_wake       = 1'b0;
        do_eret       = 1'b0;
        do_halt       = 1'b0;
        do_wrcr       = 1'b0;
        trap_code     = 3'd1;

        if (cpu_rst) begin
            {bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush} = 4'hF;
        end else if (state == ST_HALT) begin
            if (int_pend) begin
                do_wake = 1'b1;
                {bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush} = 4'hF;
                bus.new_pc = vector;
            end else begin
                {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall} = 4'hF;
            end
        end else if (bus.mem_busy) begin
            {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall} = 4'hF;
        end else if (bus.mem_en && (bus.mem_exp_code != 3'd0 || int_pend)) begin
            take_exc  = 1'b1;
            trap_code = (bus.mem_exp_code != 3'd0) ? bus.mem_exp_code : 3'd1;
            {bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush} = 4'hF;
            bus.new_pc = vector;
        end else if (bus.mem_en && bus.mem_ctrl_op == OP_ERET) begin
            do_eret = 1'b1;
            {bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush} = 4'hF;
            bus.new_pc = epc;
        end else if (bus.mem_en && bus.mem_ctrl_op == OP_HALT) begin
            // The halting instruction itself retires, so the MEM register is left alone.
            do_halt = 1'b1;
            {bus.if_flush, bus.id_flush, bus.ex_flush} = 3'b111;
            bus.new_pc = pc_plus1;
        end else if (bus.mem_en && bus.mem_ctrl_op == OP_WRCR) begin
            do_wrcr = 1'b1;
        end else if (bus.ld_hazard) begin
            bus.if_stall = 1'b1;
            bus.id_flush = 1'b1;
        end
    end

    // NOTE: registered state uses non-blocking assignment only, so every read in this block sees the pre-edge value.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state      <= ST_RUN;
            ie         <= 1'b0;
            mode       <= 1'b0;
            saved_ie   <= 1'b0;
            saved_mode <= 1'b0;
            cause      <= 3'd0;
            vector     <= 30'd0;
            epc        <= 30'd0;
            mask       <= 8'd0;
        end else if (take_exc || do_wake) begin
            // A wake keeps the EPC that was saved when HALT retired.
            if (take_exc) epc <= bus.mem_pc;
            cause      <= trap_code;
            saved_ie   <= ie;
            saved_mode <= mode;
            ie         <= 1'b0;
            mode       <= 1'b0;
            state      <= ST_RUN;
        end else if (do_eret) begin
            ie   <= saved_ie;
            mode <= saved_mode;
        end else if (do_halt) begin
            epc   <= pc_plus1;
            state <= ST_HALT;
        end else if (do_wrcr) begin
            case (bus.mem_dst_addr)
                CR_STATUS: {saved_mode, saved_ie, mode, ie} <= bus.mem_wdata[3:0];
                CR_CAUSE:  cause  <= bus.mem_wdata[2:0];
                CR_VECTOR: vector <= bus.mem_wdata[31:2];
                CR_EPC:    epc    <= bus.mem_wdata[31:2];
                CR_MASK:   mask   <= bus.mem_wdata[7:0];
                default:   ;
            endcase
        end
    end

    // The read port has no write bypass. A WRCR becomes visible in the following cycle.
    always_comb begin
        bus.creg_rd_data = 32'd0;
        case (bus.creg_rd_addr)
            CR_STATUS: bus.creg_rd_data = {28'd0, saved_mode, saved_ie, mode, ie};
            CR_CAUSE:  bus.creg_rd_data = {29'd0, cause};
            CR_VECTOR: bus.creg_rd_data = {vector, 2'b00};
            CR_EPC:    bus.creg_rd_data = {epc, 2'b00};
            CR_MASK:   bus.creg_rd_data = {24'd0, mask};
            default:   bus.creg_rd_data = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Self-checking bench for cpu_pipe_ctrl: directed plan scenarios, then randomized traffic,
// all compared against a cycle-level behavioural model of the controller.
module tb_cpu_pipe_ctrl;
    logic cpu_clk = 1'b0;
    logic cpu_rst;

    cpu_pipe_ctrl_if bus ();

    cpu_pipe_ctrl dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        bit        halted;
        bit        ie;
        bit        mode;
        bit        sie;
        bit        smode;
        bit [2:0]  cause;
        bit [29:0] vec;
        bit [29:0] epc;
        bit [7:0]  mask;
    } model_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    model_t      m;
    logic [7:0]  obs_ctl;
    logic [29:0] obs_pc;
    logic [31:0] obs_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] creg_read(input model_t s, input logic [4:0] addr);
        case (addr)
            5'd0:    return {28'd0, s.smode, s.sie, s.mode, s.ie};
            5'd1:    return {29'd0, s.cause};
            5'd2:    return {s.vec, 2'b00};
            5'd3:    return {s.epc, 2'b00};
            5'd4:    return {24'd0, s.mask};
            default: return 32'd0;
        endcase
    endfunction

    // Expected outputs packed as {if_s, id_s, ex_s, mem_s, if_f, id_f, ex_f, mem_f}.
    task automatic model_eval(input model_t cur, output bit [7:0] ctl, output bit [29:0] npc,
                              output model_t nxt);
        bit pend;
        pend = cur.ie && ((bus.irq & ~cur.mask) != 8'd0);
        nxt  = cur;
        ctl  = 8'h00;
        npc  = 30'd0;
        if (cpu_rst) begin
            ctl = 8'h0F;
            nxt = '{default: 0};
        end else if (cur.halted) begin
            if (pend) begin
                ctl         = 8'h0F;
                npc         = cur.vec;
                nxt.cause   = 3'd1;
                nxt.sie     = cur.ie;
                nxt.smode   = cur.mode;
                nxt.ie      = 1'b0;
                nxt.mode    = 1'b0;
                nxt.halted  = 1'b0;
            end else begin
                ctl = 8'hF0;
            end
        end else if (bus.mem_busy) begin
            ctl = 8'hF0;
        end else if (bus.mem_en && (bus.mem_exp_code != 3'd0 || pend)) begin
            ctl       = 8'h0F;
            npc       = cur.vec;
            nxt.epc   = bus.mem_pc;
            nxt.cause = (bus.mem_exp_code != 3'd0) ? bus.mem_exp_code : 3'd1;
            nxt.sie   = cur.ie;
            nxt.smode = cur.mode;
            nxt.ie    = 1'b0;
            nxt.mode  = 1'b0;
        end else if (bus.mem_en && bus.mem_ctrl_op == 2'd2) begin
            ctl      = 8'h0F;
            npc      = cur.epc;
            nxt.ie   = cur.sie;
            nxt.mode = cur.smode;
        end else if (bus.mem_en && bus.mem_ctrl_op == 2'd3) begin
            ctl        = 8'h0E;
            npc        = bus.mem_pc + 30'd1;
            nxt.epc    = bus.mem_pc + 30'd1;
            nxt.halted = 1'b1;
        end else if (bus.mem_en && bus.mem_ctrl_op == 2'd1) begin
            case (bus.mem_dst_addr)
                5'd0: begin
                    nxt.ie    = bus.mem_wdata[0];
                    nxt.mode  = bus.mem_wdata[1];
                    nxt.sie   = bus.mem_wdata[2];
                    nxt.smode = bus.mem_wdata[3];
                end
                5'd1: nxt.cause = bus.mem_wdata[2:0];
                5'd2: nxt.vec   = bus.mem_wdata[31:2];
                5'd3: nxt.epc   = bus.mem_wdata[31:2];
                5'd4: nxt.mask  = bus.mem_wdata[7:0];
                default: ;
            endcase
        end else if (bus.ld_hazard) begin
            ctl = 8'h84;
        end
    endtask

    task automatic idle();
        bus.mem_busy     = 1'b0;
        bus.ld_hazard    = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_pc       = 30'd0;
        bus.mem_exp_code = 3'd0;
        bus.mem_ctrl_op  = 2'd0;
        bus.mem_dst_addr = 5'd0;
        bus.mem_wdata    = 32'd0;
        bus.irq          = 8'd0;
    endtask

    // One clock: sample outputs mid-cycle, compare against the model, then advance the model.
    task automatic cycle();
        bit [7:0]  e_ctl;
        bit [29:0] e_pc;
        model_t    nxt;
        #1;
        model_eval(m, e_ctl, e_pc, nxt);
        obs_ctl = {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall,
                   bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush};
        obs_pc  = bus.new_pc;
        obs_rd  = bus.creg_rd_data;
        check("ctl", 32'(obs_ctl), 32'(e_ctl));
        if (e_ctl[3]) check("new_pc", 32'(obs_pc), 32'(e_pc));
        check("creg_rd", obs_rd, creg_read(m, bus.creg_rd_addr));
        check("exe_mode", 32'(bus.exe_mode), 32'(m.mode));
        @(posedge cpu_clk);
        #1;
        m = nxt;
    endtask

    task automatic wrcr(input logic [4:0] addr, input logic [31:0] data);
        bus.mem_en       = 1'b1;
        bus.mem_ctrl_op  = 2'd1;
        bus.mem_dst_addr = addr;
        bus.mem_wdata    = data;
        cycle();
        idle();
    endtask

    task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        idle();
        bus.creg_rd_addr = addr;
        cycle();
        check(tag, obs_rd, exp);
    endtask

    initial begin
        idle();
        bus.creg_rd_addr = 5'd0;
        cpu_rst = 1'b1;
        m = '{default: 0};
        @(posedge cpu_clk);
        #1;

        // Reset: every register reads 0 and all flushes are raised.
        for (int a = 0; a < 5; a++) begin
            bus.creg_rd_addr = 5'(a);
            cycle();
            check("rst_flush", 32'(obs_ctl), 32'h0F);
            check("rst_creg", obs_rd, 32'd0);
        end
        cpu_rst = 1'b0;
        cycle();
        check("post_rst", 32'(obs_ctl), 32'h00);

        // Load-use, alone and under mem_busy.
        bus.ld_hazard = 1'b1;
        cycle();
        check("ld_use", 32'(obs_ctl), 32'h84);
        bus.mem_busy = 1'b1;
        cycle();
        check("ld_busy", 32'(obs_ctl), 32'hF0);
        idle();

        // Synchronous exception, then ERET.
        wrcr(5'd2, 32'h100);
        wrcr(5'd0, 32'h3);
        bus.mem_en = 1'b1;
        bus.mem_pc = 30'h40;
        bus.mem_exp_code = 3'd2;
        bus.ld_hazard = 1'b1;
        cycle();
        check("exc_ctl", 32'(obs_ctl), 32'h0F);
        check("exc_pc", 32'(obs_pc), 32'h40);
        rd_check("exc_epc", 5'd3, 32'h100);
        rd_check("exc_cause", 5'd1, 32'h2);
        rd_check("exc_status", 5'd0, 32'hC);
        check("exc_mode", 32'(bus.exe_mode), 32'd0);
        idle();
        bus.mem_en = 1'b1;
        bus.mem_ctrl_op = 2'd2;
        cycle();
        check("eret_pc", 32'(obs_pc), 32'h40);
        rd_check("eret_status", 5'd0, 32'hF);
        check("eret_mode", 32'(bus.exe_mode), 32'd1);

        // Interrupt masking and the mem_en gate.
        wrcr(5'd4, 32'h04);
        bus.irq = 8'h04;
        bus.mem_en = 1'b1;
        bus.mem_pc = 30'h55;
        cycle();
        check("irq_masked", 32'(obs_ctl), 32'h00);
        idle();
        wrcr(5'd4, 32'h00);
        bus.irq = 8'h04;
        cycle();
        check("irq_no_mem_en", 32'(obs_ctl), 32'h00);
        bus.mem_en = 1'b1;
        bus.mem_pc = 30'h77;
        cycle();
        check("irq_ctl", 32'(obs_ctl), 32'h0F);
        rd_check("irq_cause", 5'd1, 32'h1);
        rd_check("irq_epc", 5'd3, 32'h1DC);

        // HALT and wake.
        wrcr(5'd0, 32'h1);
        bus.mem_en = 1'b1;
        bus.mem_ctrl_op = 2'd3;
        bus.mem_pc = 30'h20;
        cycle();
        check("halt_ctl", 32'(obs_ctl), 32'h0E);
        check("halt_pc", 32'(obs_pc), 32'h21);
        rd_check("halt_epc", 5'd3, 32'h84);
        check("halt_stall", 32'(obs_ctl), 32'hF0);
        bus.irq = 8'h01;
        cycle();
        check("wake_ctl", 32'(obs_ctl), 32'h0F);
        check("wake_pc", 32'(obs_pc), 32'h40);
        rd_check("wake_epc", 5'd3, 32'h84);
        check("wake_run", 32'(obs_ctl), 32'h00);
        rd_check("wake_cause", 5'd1, 32'h1);

        // WRCR visibility and unimplemented addresses.
        bus.creg_rd_addr = 5'd4;
        wrcr(5'd4, 32'hFF);
        check("wr_old", obs_rd, 32'h0);
        cycle();
        check("wr_new", obs_rd, 32'hFF);
        wrcr(5'd9, 32'hFFFF_FFFF);
        rd_check("addr9", 5'd9, 32'h0);
        rd_check("mask_kept", 5'd4, 32'hFF);
        rd_check("vec_kept", 5'd2, 32'h100);

        // HALT at the top of the PC space wraps EPC to 0. Reset exits HALT.
        bus.mem_en = 1'b1;
        bus.mem_ctrl_op = 2'd3;
        bus.mem_pc = 30'h3FFF_FFFF;
        cycle();
        check("wrap_pc", 32'(obs_pc), 32'h0);
        rd_check("wrap_epc", 5'd3, 32'h0);
        cpu_rst = 1'b1;
        cycle();
        cpu_rst = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cpu_rst          = ($urandom_range(0, 63) == 0);
            bus.mem_busy     = ($urandom_range(0, 5) == 0);
            bus.ld_hazard    = ($urandom_range(0, 3) == 0);
            bus.mem_en       = ($urandom_range(0, 3) != 0);
            bus.mem_pc       = 30'($urandom);
            bus.mem_exp_code = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
            bus.mem_ctrl_op  = 2'($urandom);
            bus.mem_dst_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
            bus.mem_wdata    = $urandom;
            bus.irq          = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
            bus.creg_rd_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_pipe_ctrl.md
# cpu_pipe_ctrl

Pipeline controller for the five-stage CPU core. It generates per-stage stall and flush for the IF, ID, EX and MEM pipeline registers. It owns the control-register file that the decoder reads and the MEM stage writes, and it sequences exception entry, exception return (ERET), HALT/wake and interrupt acceptance. All events are resolved at the MEM stage.

## Interface
- No parameters.
- cpu_clk  in  1  core clock; all state updates on the rising edge.
- cpu_rst  in  1  reset, synchronous, active-high.
- mem_busy  in  1  bus access in MEM stage not complete.
- ld_hazard  in  1  load-use hazard detected by the decoder.
- mem_en  in  1  MEM stage holds a valid instruction.
- mem_pc  in  30  word PC of the MEM-stage instruction.
- mem_exp_code  in  3  exception code carried by the MEM-stage instruction; 0 means none.
- mem_ctrl_op  in  2  control operation: 0 NOP, 1 WRCR, 2 ERET, 3 HALT.
- mem_dst_addr  in  5  control-register write address used by WRCR.
- mem_wdata  in  32  control-register write data used by WRCR.
- irq  in  8  level-sensitive interrupt requests.
- creg_rd_addr  in  5  decoder control-register read address.
- creg_rd_data  out  32  control-register read data.
- exe_mode  out  1  current mode: 0 kernel, 1 user.
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold the stage register.
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  load a bubble into the stage register.
- new_pc  out  30  redirect target, valid when if_flush=1.

## Operation
**Control registers**
- Unimplemented addresses read 0 and ignore writes.
- Register 0, STATUS:
  - bit0 ie
  - bit1 mode
  - bit2 saved_ie
  - bit3 saved_mode
- Register 1, CAUSE: bits[2:0] hold the last exception code.
- Register 2, VECTOR: bits[31:2] hold the vector; bits[1:0] read 0.
- Register 3, EPC: bits[31:2] hold the return address; bits[1:0] read 0.
- Register 4, MASK: bits[7:0]; a set bit masks the corresponding irq.

**Interrupt pending:** int_pend = STATUS.ie & |(irq & ~MASK).

**State machine states:** RUN, HALT.

**RUN priority, highest first**
1. **mem_busy=1.** All four stalls are 1. All flushes are 0. No state changes.
2. **Exception.** Condition: mem_en=1 and (mem_exp_code≠0 or int_pend=1).
   - Code = mem_exp_code if nonzero, else 1 (external interrupt).
   - All four flushes are 1; new_pc = VECTOR[31:2].
   - At the clock edge:
     - EPC ← mem_pc.
     - CAUSE ← code.
     - saved_ie/saved_mode ← ie/mode.
     - ie ← 0, mode ← 0.
   - The ctrl_op of the excepting instruction is ignored.
3. **mem_en=1 and ERET.** All four flushes are 1; new_pc = EPC.
   - At the clock edge: ie/mode ← saved_ie/saved_mode.
4. **mem_en=1 and HALT.** if_flush, id_flush and ex_flush are 1; new_pc = mem_pc+1, modulo 2^30.
   - At the clock edge: EPC ← mem_pc+1; next state is HALT.
5. **mem_en=1 and WRCR.** The register at mem_dst_addr ← mem_wdata at the clock edge. No stall or flush is generated.
6. **ld_hazard=1.** if_stall=1 and id_flush=1, which inserts a bubble into EX. All other stalls and flushes are 0.

**HALT state**
- if_stall, id_stall, ex_stall and mem_stall are all 1.
- When int_pend=1:
  - All four flushes are 1; new_pc = VECTOR.
  - CAUSE ← 1; EPC keeps the value already saved at HALT.
  - Status is saved and cleared as in an exception.
  - Next state is RUN.

**Read port:** creg_rd_data is combinational from creg_rd_addr. There is no write bypass: a WRCR write becomes visible to reads in the cycle after it is committed.

## Timing
- All stall, flush and new_pc outputs are combinational from the current-cycle inputs and state. Zero-cycle latency.
- Register updates and state transitions take effect at the next cpu_clk edge.
- In any cycle where flush=1 for a stage, stall=0 for that stage.

**Reset (cpu_rst=1 sampled at an edge)**
- State ← RUN.
- STATUS ← 0, so ie=0 and mode=kernel.
- CAUSE, VECTOR, EPC and MASK ← 0.
- Reset overrides any event in progress, including a HALT or exception in the same cycle.
- While cpu_rst=1, all flushes are 1, all stalls are 0, and new_pc=0.

**Simultaneous events**
- Exception combined with ld_hazard: the exception wins and ld_hazard is ignored.
- mem_busy combined with an exception: the exception is deferred until mem_busy=0.
- int_pend while mem_en=0 in RUN: not taken; it waits for a valid MEM instruction.
- HALT at mem_pc=0x3FFFFFFF: EPC wraps to 0.

## Test plan
1. **Reset.** Hold cpu_rst for 2 cycles → every creg reads 0, exe_mode=0, all flushes=1; after release all flushes and stalls are 0.
2. **Load-use.** ld_hazard=1 for 1 cycle → if_stall=1, id_flush=1, all others 0. With mem_busy=1 in the same cycle → all four stalls=1, id_flush=0.
3. **Synchronous exception.**
   - Setup: VECTOR=0x100, mem_pc=0x40, mem_exp_code=2, STATUS=0x3.
   - Expect: all flushes=1, new_pc=0x40; next cycle EPC=0x100, CAUSE=2, STATUS=0xC, exe_mode=0.
   - Then ERET → new_pc=0x40 (EPC), STATUS=0xF, exe_mode=1.
4. **Interrupt masking.** ie=1, irq=0x04.
   - MASK=0x04 → not taken.
   - MASK=0x00 with mem_en=1 → CAUSE=1, EPC=mem_pc.
5. **HALT and wake.** HALT at mem_pc=0x20 → 3 flushes, then all stalls in HALT; EPC=0x21. With irq=0x01 and ie=1 → flushes, new_pc=VECTOR, EPC stays 0x21, back to RUN.
6. **WRCR visibility.** WRCR addr=4, data=0xFF, with creg_rd_addr=4 in the same cycle → reads old value; next cycle reads 0x000000FF. Write to addr=9 → all registers unchanged, addr 9 reads 0.
